// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//   Multi-cycle subtractor computing Y = A - B - BorrowIN (mod 2^WIDTH).
//   Each RUN cycle handles DIGIT bits, LSB digit first. The borrow is carried
//   between cycles in a register. A Start/Busy/Done handshake frames each
//   operation.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   Start      request; only accepted in IDLE or DONE
//   A, B       minuend / subtrahend, latched on an accepted Start
//   BorrowIN   initial borrow, latched on an accepted Start
//   Busy       high while digits are being processed (RUN)
//   Done       one-cycle pulse; result outputs are valid
//   Y          difference, held until the next completion or reset
//   BorrowOUT  final borrow (unsigned A < B + BorrowIN)
//   Overflow   two's-complement overflow of the signed difference
//   Zero       Y == 0
module digit_serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIN,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Y,
  output logic             BorrowOUT,
  output logic             Overflow,
  output logic             Zero
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             bo_q, bo_d, ov_q, ov_d, z_q, z_d;

  logic [DIGIT:0]         digit_diff;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;
  logic                   last_digit;

  // Operands shift right so the current digit is always in the low bits; the
  // sign bits are kept separately for the overflow flag.
  assign digit_diff = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};
  // New digit enters at the top; after N digits digit 0 sits at the LSB.
  // The wide concat keeps this legal when DIGIT == WIDTH.
  assign res_cat    = {digit_diff[DIGIT-1:0], res_q};
  assign res_shift  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    y_d      = y_q;
    bo_d     = bo_q;
    ov_d     = ov_q;
    z_d      = z_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (Start) begin
          state_d  = StRun;
          a_sh_d   = A;
          b_sh_d   = B;
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
          borrow_d = BorrowIN;
          cnt_d    = '0;
          res_d    = '0;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        res_d    = res_shift;
        borrow_d = digit_diff[DIGIT];
        cnt_d    = cnt_q + 1'b1;
        if (last_digit) begin
          state_d = StDone;
          y_d     = res_shift;
          bo_d    = digit_diff[DIGIT];
          ov_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          z_d     = ~|res_shift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      y_q      <= '0;
      bo_q     <= 1'b0;
      ov_q     <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      y_q      <= y_d;
      bo_q     <= bo_d;
      ov_q     <= ov_d;
      z_q      <= z_d;
    end
  end

  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);
  assign Y         = y_q;
  assign BorrowOUT = bo_q;
  assign Overflow  = ov_q;
  assign Zero      = z_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Scoreboard bench for digit_serial_subtractor: an 8-bit/2-bit instance and a
// 4-bit/4-bit (single digit) instance share clock and reset. Expected results
// are hand-computed and queued at issue; monitors pop them on Done.
module tb_digit_serial_subtractor;

  typedef struct packed {
    logic [7:0] y;
    logic       bo;
    logic       ov;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start8, BI8, Busy8, Done8, BO8, OV8, Z8;
  logic [7:0] A8, B8, Y8;
  logic       Start4, BI4, Busy4, Done4, BO4, OV4, Z4;
  logic [3:0] A4, B4, Y4;

  exp_t q8[$];
  exp_t q4[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .Start(Start8), .A(A8), .B(B8), .BorrowIN(BI8),
    .Busy(Busy8), .Done(Done8), .Y(Y8), .BorrowOUT(BO8), .Overflow(OV8), .Zero(Z8)
  );

  digit_serial_subtractor #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .Start(Start4), .A(A4), .B(B4), .BorrowIN(BI4),
    .Busy(Busy4), .Done(Done4), .Y(Y4), .BorrowOUT(BO4), .Overflow(OV4), .Zero(Z4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitors: compare every Done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && Done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'(Done8), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("y8", 32'(Y8), 32'(e.y));
        chk("borrow8", 32'(BO8), 32'(e.bo));
        chk("overflow8", 32'(OV8), 32'(e.ov));
        chk("zero8", 32'(Z8), 32'(e.z));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && Done4) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 32'(Done4), 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("y4", 32'(Y4), 32'(e.y));
        chk("borrow4", 32'(BO4), 32'(e.bo));
        chk("overflow4", 32'(OV4), 32'(e.ov));
        chk("zero4", 32'(Z4), 32'(e.z));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs so a design
  // that fails to latch them produces a wrong result.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input exp_t e);
    A8 = a; B8 = b; BI8 = bi; Start8 = 1'b1;
    q8.push_back(e);
    tick();
    Start8 = 1'b0; A8 = ~a; B8 = b ^ 8'h5A; BI8 = ~bi;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input exp_t e);
    A4 = a; B4 = b; BI4 = bi; Start4 = 1'b1;
    q4.push_back(e);
    tick();
    Start4 = 1'b0; A4 = ~a; B4 = ~b; BI4 = ~bi;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
    tick();
  endtask

  initial begin
    exp_t stream_exp [4];
    reset = 1'b1;
    Start8 = 1'b0; A8 = '0; B8 = '0; BI8 = 1'b0;
    Start4 = 1'b0; A4 = '0; B4 = '0; BI4 = 1'b0;
    // Start during reset must be ignored.
    repeat (2) tick();
    Start8 = 1'b1; A8 = 8'h33; B8 = 8'h11;
    tick();
    Start8 = 1'b0;
    reset = 1'b0;
    chk("rst_busy8", 32'(Busy8), 32'd0);
    chk("rst_done8", 32'(Done8), 32'd0);
    chk("rst_y8", 32'(Y8), 32'd0);
    chk("rst_flags8", 32'({BO8, OV8, Z8}), 32'd0);
    chk("rst_busy4", 32'(Busy4), 32'd0);
    chk("rst_y4", 32'({Y4, BO4, OV4, Z4}), 32'd0);
    tick();

    // 0x06 - 0x02 with cycle-exact handshake checks.
    issue8(8'h06, 8'h02, 1'b0, '{y: 8'h04, bo: 1'b0, ov: 1'b0, z: 1'b0});
    for (int m = 0; m < 4; m++) begin
      chk("busy_run", 32'(Busy8), 32'd1);
      chk("done_run", 32'(Done8), 32'd0);
      tick();
    end
    chk("done_pulse", 32'(Done8), 32'd1);
    chk("busy_done", 32'(Busy8), 32'd0);
    tick();
    chk("done_once", 32'(Done8), 32'd0);
    drain();

    issue8(8'h02, 8'h06, 1'b0, '{y: 8'hFC, bo: 1'b1, ov: 1'b0, z: 1'b0});
    tick();
    chk("y_hold_in_run", 32'(Y8), 32'h04);
    drain();
    issue8(8'h80, 8'h01, 1'b0, '{y: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0});
    drain();
    issue8(8'hFF, 8'h01, 1'b1, '{y: 8'hFD, bo: 1'b0, ov: 1'b0, z: 1'b0});
    drain();
    issue8(8'h08, 8'h08, 1'b0, '{y: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1});
    drain();
    issue8(8'h55, 8'h55, 1'b1, '{y: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0});
    drain();
    issue8(8'h7F, 8'hFF, 1'b0, '{y: 8'h80, bo: 1'b1, ov: 1'b1, z: 1'b0});
    drain();

    // Start held high, operands change every cycle (A=0x40+j, B=2j, BI=j[0]);
    // only cycles 0, 5, 10, 15 are accepted.
    stream_exp[0] = '{y: 8'h40, bo: 1'b0, ov: 1'b0, z: 1'b0};
    stream_exp[1] = '{y: 8'h3A, bo: 1'b0, ov: 1'b0, z: 1'b0};
    stream_exp[2] = '{y: 8'h36, bo: 1'b0, ov: 1'b0, z: 1'b0};
    stream_exp[3] = '{y: 8'h30, bo: 1'b0, ov: 1'b0, z: 1'b0};
    for (int j = 0; j < 20; j++) begin
      A8 = 8'(8'h40 + j);
      B8 = 8'(j * 2);
      BI8 = j[0];
      Start8 = (j <= 15);
      if (j % 5 == 0) q8.push_back(stream_exp[j / 5]);
      tick();
      chk("stream_done", 32'(Done8), 32'(j % 5 == 4));
    end
    Start8 = 1'b0;
    drain();

    // Reset during the 2nd RUN cycle of 0x10 - 0x01 aborts the operation.
    A8 = 8'h10; B8 = 8'h01; BI8 = 1'b0; Start8 = 1'b1;
    tick();
    Start8 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(Busy8), 32'd0);
    chk("abort_done", 32'(Done8), 32'd0);
    chk("abort_y", 32'(Y8), 32'd0);
    chk("abort_flags", 32'({BO8, OV8, Z8}), 32'd0);
    repeat (6) tick();
    issue8(8'h10, 8'h01, 1'b0, '{y: 8'h0F, bo: 1'b0, ov: 1'b0, z: 1'b0});
    drain();

    // Single-digit instance: Done two cycles after Start.
    issue4(4'h0, 4'h0, 1'b1, '{y: 8'h0F, bo: 1'b1, ov: 1'b0, z: 1'b0});
    chk("n1_busy", 32'(Busy4), 32'd1);
    chk("n1_done_early", 32'(Done4), 32'd0);
    tick();
    chk("n1_done", 32'(Done4), 32'd1);
    chk("n1_busy_done", 32'(Busy4), 32'd0);
    drain();
    issue4(4'h8, 4'h1, 1'b0, '{y: 8'h07, bo: 1'b0, ov: 1'b1, z: 1'b0});
    drain();
    issue4(4'h5, 4'h5, 1'b0, '{y: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
